// File: rtl/gemm_sequencer_if.sv
// Command encoding shared by the sequencer and the GEMM datapath, plus the job/stream interface.
// The master modport belongs to the job source and activation producer, and the slave modport to the sequencer.
// Widths follow SA_SIZE (array dimension), WA_SIZE (element width) and CNT_W (row counter width).
package gemm_seq_pkg;
    typedef enum logic [1:0] {
        CMD_IDLE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_COMPUTE       = 2'd2
    } command_t;
endpackage

interface gemm_sequencer_if #(
    parameter int SA_SIZE = 4,
    parameter int WA_SIZE = 8,
    parameter int CNT_W   = 16
);
    // Job control
    logic                               start;
    logic                               abort;
    logic [CNT_W-1:0]                   row_count;
    logic [WA_SIZE*SA_SIZE*SA_SIZE-1:0] w_tile;
    // Activation stream (valid/ready)
    logic                               act_valid;
    logic                               act_ready;
    logic [WA_SIZE*SA_SIZE-1:0]         act_row;
    // GEMM datapath drive
    gemm_seq_pkg::command_t             gemm_cmd;
    logic [WA_SIZE*SA_SIZE*SA_SIZE-1:0] gemm_weights;
    logic [WA_SIZE*SA_SIZE-1:0]         gemm_act;
    // Result framing and status
    logic                               out_valid;
    logic                               out_last;
    logic                               busy;
    logic                               done;

    modport master (
        output start, abort, row_count, w_tile, act_valid, act_row,
        input  act_ready, gemm_cmd, gemm_weights, gemm_act, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, abort, row_count, w_tile, act_valid, act_row,
        output act_ready, gemm_cmd, gemm_weights, gemm_act, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/gemm_sequencer.sv
// Job sequencer for the GEMM datapath: weight load, activation row streaming, result row tagging.
// Latency: one LOAD_W cycle after start; each accepted row reappears as out_valid PIPE_LAT cycles later.
// Backpressure: act_ready gates the input stream; the output has no backpressure and rows must be consumed.
// Ports: clk, resetn (async active-low), bus (slave modport: job control, activation stream, GEMM drive, result flags).
module gemm_sequencer #(
    parameter int SA_SIZE  = 4,
    parameter int WA_SIZE  = 8,
    parameter int PIPE_LAT = 2 * SA_SIZE,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    gemm_sequencer_if.slave   bus
);
    import gemm_seq_pkg::*;

    localparam int TILE_W = WA_SIZE * SA_SIZE * SA_SIZE;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]          state_q;
    logic [1:0]          state_nxt;
    command_t            cmd_q;
    command_t            cmd_nxt;
    logic [TILE_W-1:0]   w_q;
    logic [CNT_W-1:0]    row_cnt_q;
    logic [CNT_W-1:0]    rows_sent_q;
    logic [CNT_W-1:0]    rows_out_q;
    logic [CNT_W-1:0]    row_last;
    logic [PIPE_LAT-1:0] tag_q;
    logic                done_zero_q;

    logic job_accept;
    logic zero_accept;
    logic abort_job;
    logic act_fire;
    logic out_vld;
    logic last_out;

    // abort in IDLE only suppresses a simultaneous start; it has nothing to cancel
    assign abort_job   = bus.abort && (state_q != ST_IDLE);
    assign job_accept  = (state_q == ST_IDLE) && bus.start && !bus.abort && (bus.row_count != '0);
    assign zero_accept = (state_q == ST_IDLE) && bus.start && !bus.abort && (bus.row_count == '0);
    assign row_last    = row_cnt_q - CNT_W'(1);

    // abort masks ready so a row offered in the abort cycle stays with the producer
    assign bus.act_ready = (state_q == ST_STREAM) && (rows_sent_q < row_cnt_q) && !bus.abort;
    assign act_fire      = bus.act_valid && bus.act_ready;
    assign bus.gemm_act  = act_fire ? bus.act_row : '0;

    // Tail of the tag pipe lines up with the GEMM output of the row that set it
    assign out_vld  = tag_q[PIPE_LAT-1];
    assign last_out = out_vld && (rows_out_q == row_last);

    assign bus.out_valid    = out_vld;
    assign bus.out_last     = last_out;
    assign bus.done         = last_out || done_zero_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.gemm_cmd     = cmd_q;
    assign bus.gemm_weights = w_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (job_accept) state_nxt = ST_LOAD_W;
            ST_LOAD_W: state_nxt = ST_STREAM;
            ST_STREAM: if (act_fire && (rows_sent_q == row_last)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (last_out) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_job) state_nxt = ST_IDLE;
    end

    // The command is registered alongside the state so it is a clean flop output to the array
    always_comb begin
        cmd_nxt = CMD_IDLE;
        case (state_nxt)
            ST_LOAD_W:          cmd_nxt = CMD_WRITE_WEIGHTS;
            ST_STREAM, ST_DRAIN: cmd_nxt = CMD_COMPUTE;
            default:            cmd_nxt = CMD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_IDLE;
            w_q         <= '0;
            row_cnt_q   <= '0;
            rows_sent_q <= '0;
            rows_out_q  <= '0;
            tag_q       <= '0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cmd_q       <= cmd_nxt;
            done_zero_q <= zero_accept;
            if (job_accept) begin
                w_q       <= bus.w_tile;
                row_cnt_q <= bus.row_count;
            end
            if (abort_job || job_accept) begin
                rows_sent_q <= '0;
                rows_out_q  <= '0;
                tag_q       <= '0;
            end else begin
                if (act_fire) rows_sent_q <= rows_sent_q + CNT_W'(1);
                if (out_vld && (rows_out_q < row_cnt_q)) rows_out_q <= rows_out_q + CNT_W'(1);
                // The array only advances under CMD_COMPUTE, so the tags must do the same
                if (cmd_q == CMD_COMPUTE) tag_q <= {tag_q[PIPE_LAT-2:0], act_fire};
            end
        end
    end
endmodule
